// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle RV32I core.
//   - RV32I opcode and funct3 constants
//   - state_t : FSM states of the core sequencer
//   - alu_op_t: operations understood by mc_alu
//   - alu_decode(): maps funct3 plus the funct7[5] "alternate" bit to an alu_op_t
package mc_pkg;

  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] JAL    = 7'h6f;
  localparam logic [6:0] JALR   = 7'h67;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;

  // ALU funct3 encodings
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  // Branch funct3 encodings
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  // alt selects SUB over ADD and SRA over SRL; callers must clear it
  // where funct7 does not exist (e.g. ADDI, whose imm may have bit 30 set).
  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu.sv
// mc_alu: combinational 32-bit integer ALU.
//   op  : operation select (alu_op_t)
//   a, b: operands
//   y   : result, modulo 2^32, shift amount is b[4:0]
//   eq, lt, ltu: a==b, signed a<b, unsigned a<b (branch conditions)
module mc_alu
  import mc_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  always_comb begin
    y = a + b;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'd0, lt};
      ALU_SLTU: y = {31'd0, ltu};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $signed(a) >>> b[4:0];
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end

endmodule

// File: rtl/mc_storage.sv
// Storage blocks of the core. None of them has a reset: contents persist
// across core resets. Word index inputs are already reduced modulo depth.
//
// mc_imem   : read-only instruction array mem, combinational read (idx -> rdata).
//             Contents are preloaded from outside the design.
// mc_regfile: 32x32 register file, two combinational read ports (ra1/ra2 ->
//             rd1/rd2) and one synchronous write port (we, wa, wd). x0 reads 0
//             and ignores writes.
// mc_dmem   : data array mem, combinational read (idx -> rdata), synchronous
//             write (we, wdata) to the same index.
module mc_imem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic [AW-1:0] idx,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:WORDS-1];
  assign rdata = mem[idx];
endmodule

module mc_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] file [0:31];

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : file[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : file[ra2];

  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) file[wa] <= wd;
  end
endmodule

module mc_dmem #(
  parameter int WORDS = 64,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:WORDS-1];

  assign rdata = mem[idx];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end
endmodule

// File: rtl/mc_core.sv
// mc_core: multi-cycle RV32I integer core, one instruction at a time through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
//   clk    : single clock, all state changes on the rising edge
//   areset : synchronous active-high reset (sampled on clk only). Resets the
//            sequencer and its holding registers; register file and memories
//            keep their contents. A reset in the middle of an instruction
//            blocks any pending register-file or data-memory write.
// No functional outputs; state lives in instrMem, registerFile, dataMemory.
module mc_core
  import mc_pkg::*;
#(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic areset
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  state_t      state;
  logic [31:0] pc, ir, oldpc, a_q, b_q, aluout, mdr;

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        f7b5;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7b5   = ir[30];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'd0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // Storage
  logic [31:0] imem_rdata, rs1_val, rs2_val, dmem_rdata, rf_wd;
  logic        rf_we, dmem_we;

  mc_imem #(.WORDS(IMEM_WORDS)) instrMem (
    .idx   (pc[IAW+1:2]),
    .rdata (imem_rdata)
  );

  mc_regfile registerFile (
    .clk (clk),
    .we  (rf_we),
    .wa  (rd),
    .wd  (rf_wd),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rs1_val),
    .rd2 (rs2_val)
  );

  mc_dmem #(.WORDS(DMEM_WORDS)) dataMemory (
    .clk   (clk),
    .we    (dmem_we),
    .idx   (aluout[DAW+1:2]),
    .wdata (b_q),
    .rdata (dmem_rdata)
  );

  // Writes are gated by areset so a reset aborts the instruction cleanly.
  assign rf_we   = (state == WRITEBACK) && !areset;
  assign rf_wd   = (opcode == LOAD) ? mdr : aluout;
  assign dmem_we = (state == MEMORY) && (opcode == STORE) && !areset;

  // ALU operand/op selection for EXECUTE
  alu_op_t     alu_op;
  logic [31:0] alu_b, alu_y;
  logic        alu_eq, alu_lt, alu_ltu;

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = b_q;
    case (opcode)
      OP:          alu_op = alu_decode(f3, f7b5);
      OP_IMM: begin
        // Only SRAI carries a funct7; ADDI's imm bit 30 must not mean SUB.
        alu_op = alu_decode(f3, (f3 == F3_SR) && f7b5);
        alu_b  = imm_i;
      end
      LOAD, JALR:  alu_b = imm_i;
      STORE:       alu_b = imm_s;
      default:     alu_b = b_q;
    endcase
  end

  mc_alu alu (
    .op  (alu_op),
    .a   (a_q),
    .b   (alu_b),
    .y   (alu_y),
    .eq  (alu_eq),
    .lt  (alu_lt),
    .ltu (alu_ltu)
  );

  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (f3)
      F3_BEQ:  br_taken = alu_eq;
      F3_BNE:  br_taken = !alu_eq;
      F3_BLT:  br_taken = alu_lt;
      F3_BGE:  br_taken = !alu_lt;
      F3_BLTU: br_taken = alu_ltu;
      F3_BGEU: br_taken = !alu_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  logic is_nop;
  always_comb begin
    case (opcode)
      OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC: is_nop = 1'b0;
      default:                                                is_nop = 1'b1;
    endcase
  end

  // Sequencer
  always_ff @(posedge clk) begin
    if (areset) begin
      pc     <= RESET_PC;
      state  <= FETCH;
      ir     <= 32'd0;
      oldpc  <= 32'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      aluout <= 32'd0;
      mdr    <= 32'd0;
    end else begin
      case (state)
        FETCH: begin
          ir    <= imem_rdata;
          oldpc <= pc;
          pc    <= pc + 32'd4;
          state <= DECODE;
        end
        DECODE: begin
          a_q   <= rs1_val;
          b_q   <= rs2_val;
          state <= is_nop ? FETCH : EXECUTE;
        end
        EXECUTE: begin
          case (opcode)
            OP, OP_IMM: begin
              aluout <= alu_y;
              state  <= WRITEBACK;
            end
            LOAD, STORE: begin
              aluout <= alu_y;
              state  <= MEMORY;
            end
            BRANCH: begin
              if (br_taken) pc <= oldpc + imm_b;
              state <= FETCH;
            end
            JAL: begin
              pc     <= oldpc + imm_j;
              aluout <= oldpc + 32'd4;
              state  <= WRITEBACK;
            end
            JALR: begin
              pc     <= {alu_y[31:1], 1'b0};
              aluout <= oldpc + 32'd4;
              state  <= WRITEBACK;
            end
            LUI: begin
              aluout <= imm_u;
              state  <= WRITEBACK;
            end
            AUIPC: begin
              aluout <= oldpc + imm_u;
              state  <= WRITEBACK;
            end
            default: state <= FETCH;
          endcase
        end
        MEMORY: begin
          if (opcode == LOAD) begin
            mdr   <= dmem_rdata;
            state <= WRITEBACK;
          end else begin
            state <= FETCH;
          end
        end
        WRITEBACK: state <= FETCH;
        default:   state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core: programs are placed in instrMem.mem, each
// instruction is stepped and its cycle count and next PC checked, then the
// architectural results in registerFile / dataMemory are compared.
module tb_mc_core;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic areset = 1'b1;

  mc_core dut (
    .clk    (clk),
    .areset (areset)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  logic [31:0] prog_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  // ---------------- driver / scoreboard tasks ----------------
  task automatic load_prog();
    for (int i = 0; i < 256; i++) dut.instrMem.mem[i] = 32'd0;
    for (int i = 0; i < prog_q.size(); i++) dut.instrMem.mem[i] = prog_q[i];
    prog_q.delete();
  endtask

  task automatic do_reset(input int n);
    areset = 1'b1;
    repeat (n) @(posedge clk);
    #1 areset = 1'b0;
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      n_checks++;
      assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  // Step one instruction from FETCH back to FETCH (bounded), check cycles and PC.
  task automatic run_instr(input string tag, input int exp_cyc, input logic [31:0] exp_pc);
    int cycles;
    expect_val(32'(exp_cyc));
    expect_val(exp_pc);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (dut.state != FETCH && cycles < 16);
    check({tag, "_cycles"}, 32'(cycles));
    check({tag, "_pc"}, dut.pc);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cnt;

    // Preload state that reset must not touch
    dut.registerFile.file[20] = 32'h1234_5678;
    dut.registerFile.file[9]  = 32'd0;
    dut.registerFile.file[13] = 32'hDEAD_BEEF;
    dut.dataMemory.mem[5]     = 32'hCAFE_BABE;

    // ALU program
    prog_q.push_back(enc_i(12'd5,   5'd0, F3_ADD, 5'd1, OP_IMM));
    prog_q.push_back(enc_i(12'hFFD, 5'd0, F3_ADD, 5'd2, OP_IMM));
    prog_q.push_back(enc_r(7'h00, 5'd2, 5'd1, F3_ADD, 5'd3));
    prog_q.push_back(enc_r(7'h20, 5'd2, 5'd1, F3_ADD, 5'd4));
    prog_q.push_back(enc_i(12'h401, 5'd2, F3_SR,   5'd5, OP_IMM));
    prog_q.push_back(enc_r(7'h00, 5'd2, 5'd1, F3_SLTU, 5'd6));
    load_prog();

    // Reset: two cycles held
    do_reset(2);
    expect_val(32'd0);                 check("rst_pc", dut.pc);
    expect_val({29'd0, FETCH});        check("rst_state", {29'd0, dut.state});
    expect_val(32'd0);                 check("rst_ir", dut.ir);
    expect_val(32'h1234_5678);         check("rst_rf_keep", dut.registerFile.file[20]);
    expect_val(32'hCAFE_BABE);         check("rst_dmem_keep", dut.dataMemory.mem[5]);

    // ALU
    run_instr("addi_x1", 4, 32'h04);
    run_instr("addi_x2", 4, 32'h08);
    run_instr("add_x3",  4, 32'h0C);
    run_instr("sub_x4",  4, 32'h10);
    run_instr("srai_x5", 4, 32'h14);
    run_instr("sltu_x6", 4, 32'h18);
    expect_val(32'd5);          check("x1", dut.registerFile.file[1]);
    expect_val(32'hFFFF_FFFD);  check("x2", dut.registerFile.file[2]);
    expect_val(32'd2);          check("x3", dut.registerFile.file[3]);
    expect_val(32'd8);          check("x4", dut.registerFile.file[4]);
    expect_val(32'hFFFF_FFFE);  check("x5", dut.registerFile.file[5]);
    expect_val(32'd1);          check("x6", dut.registerFile.file[6]);

    // Memory
    prog_q.push_back(enc_i(12'd42, 5'd0, F3_ADD, 5'd1, OP_IMM));
    prog_q.push_back(enc_s(12'd8,   5'd1, 5'd0));
    prog_q.push_back(enc_i(12'd8,   5'd0, 3'd2, 5'd7, LOAD));
    prog_q.push_back(enc_s(12'd256, 5'd1, 5'd0));
    load_prog();
    dut.dataMemory.mem[0] = 32'h5A5A_5A5A;
    dut.dataMemory.mem[2] = 32'd0;
    do_reset(1);
    run_instr("addi_42", 4, 32'h04);
    run_instr("sw_8",    4, 32'h08);
    expect_val(32'd42);  check("dmem2", dut.dataMemory.mem[2]);
    run_instr("lw_8",    5, 32'h0C);
    expect_val(32'd42);  check("x7", dut.registerFile.file[7]);
    run_instr("sw_256",  4, 32'h10);
    expect_val(32'd42);  check("dmem0_wrap", dut.dataMemory.mem[0]);

    // Branch / jump
    prog_q.push_back(enc_b(13'd8, 5'd0, 5'd0, F3_BEQ));          // 0x00
    prog_q.push_back(enc_i(12'd1, 5'd0, F3_ADD, 5'd9, OP_IMM));  // 0x04 skipped
    prog_q.push_back(32'd0);                                     // 0x08
    prog_q.push_back(32'd0);                                     // 0x0C
    prog_q.push_back(enc_j(21'd12, 5'd1));                       // 0x10
    prog_q.push_back(enc_i(12'd3, 5'd0, F3_ADD, 5'd10, OP_IMM)); // 0x14
    prog_q.push_back(enc_b(13'd8, 5'd0, 5'd0, F3_BNE));          // 0x18
    prog_q.push_back(enc_i(12'd0, 5'd1, 3'd0, 5'd0, JALR));      // 0x1C
    load_prog();
    do_reset(1);
    run_instr("beq_taken", 3, 32'h08);
    run_instr("nop_08",    2, 32'h0C);
    run_instr("nop_0c",    2, 32'h10);
    run_instr("jal",       4, 32'h1C);
    expect_val(32'h14);  check("jal_link", dut.registerFile.file[1]);
    run_instr("jalr",      4, 32'h14);
    run_instr("addi_x10",  4, 32'h18);
    run_instr("bne_fall",  3, 32'h1C);
    expect_val(32'd0);   check("x9_skipped", dut.registerFile.file[9]);
    expect_val(32'd3);   check("x10", dut.registerFile.file[10]);

    // x0, NOPs, LUI, AUIPC
    prog_q.push_back(enc_i(12'd7, 5'd0, F3_ADD, 5'd0, OP_IMM));  // 0x00
    prog_q.push_back(32'd0);                                     // 0x04
    prog_q.push_back(enc_u(20'h12345, 5'd8, LUI));               // 0x08
    prog_q.push_back(32'h0000_000F);                             // 0x0C fence
    prog_q.push_back(32'd0);                                     // 0x10
    prog_q.push_back(32'd0);                                     // 0x14
    prog_q.push_back(32'd0);                                     // 0x18
    prog_q.push_back(32'd0);                                     // 0x1C
    prog_q.push_back(enc_u(20'h00001, 5'd12, AUIPC));            // 0x20
    load_prog();
    do_reset(1);
    run_instr("addi_x0", 4, 32'h04);
    expect_val(32'd0);  check("x0_zero", dut.registerFile.file[0]);
    run_instr("nop_zero", 2, 32'h08);
    run_instr("lui",      4, 32'h0C);
    expect_val(32'h1234_5000);  check("x8_lui", dut.registerFile.file[8]);
    run_instr("fence_nop", 2, 32'h10);
    for (int i = 0; i < 4; i++) run_instr("nop_pad", 2, 32'h14 + 32'(i) * 4);
    run_instr("auipc", 4, 32'h24);
    expect_val(32'h0000_1020);  check("x12_auipc", dut.registerFile.file[12]);

    // Reset in the middle of LW
    prog_q.push_back(enc_i(12'd8, 5'd0, 3'd2, 5'd13, LOAD));
    load_prog();
    do_reset(1);
    cnt = 0;
    while (dut.state != MEMORY && cnt < 10) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    expect_val({29'd0, MEMORY});  check("lw_reach_mem", {29'd0, dut.state});
    areset = 1'b1;
    @(posedge clk);
    #1 areset = 1'b0;
    // Give a would-be writeback time to show up
    @(posedge clk);
    #1;
    expect_val(32'hDEAD_BEEF);  check("abort_no_write", dut.registerFile.file[13]);
    expect_val(32'h04);         check("restart_pc", dut.pc);
    // Restart from PC 0 completes the LW normally
    do_reset(1);
    expect_val(32'd0);          check("abort_mdr", dut.mdr);
    run_instr("lw_restart", 5, 32'h04);
    expect_val(32'd42);         check("x13_after", dut.registerFile.file[13]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
